// File: rtl/conv_weight_loader_pkg.sv
// Shared definitions for the conv-layer controller slice: weight-loader
// state encoding, default array geometry and an index-width helper.
package cnn_ctrl_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ARRAY_N_DEF = 4;
  localparam int unsigned ADDR_W_DEF  = 10;

  // Bits needed to index n items; never less than 1 so n=1 still yields a port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ROW_W_DEF = idx_w(ARRAY_N_DEF);

  typedef enum logic [2:0] {
    WL_IDLE,
    WL_FETCH,
    WL_DRAIN,
    WL_DONE,
    WL_RELEASE
  } wl_state_e;

endpackage

// File: rtl/conv_weight_loader_if.sv
// Weight-loader bundle: controller request/done, weight SRAM read port and
// row delivery to the systolic array. slave = loader side, master = environment.
interface conv_weight_loader_if
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ARRAY_N = ARRAY_N_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
);
  localparam int unsigned ROW_W = idx_w(ARRAY_N);

  logic                      load_i;
  logic [ADDR_W-1:0]         base_addr_i;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      w_valid;
  logic [ROW_W-1:0]          w_row;
  logic [ARRAY_N*DATA_W-1:0] w_data;
  logic                      done;

  modport slave (
    input  load_i, base_addr_i, mem_rdata,
    output mem_rd_en, mem_addr, w_valid, w_row, w_data, done
  );

  modport master (
    output load_i, base_addr_i, mem_rdata,
    input  mem_rd_en, mem_addr, w_valid, w_row, w_data, done
  );

endinterface

// File: rtl/conv_weight_loader_row_buf.sv
// wload_row_buf: ARRAY_N-slot capture register; writing the last slot publishes
// the completed row to a hold register and pulses full_o the following cycle.
module wload_row_buf #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ARRAY_N = 4,
  parameter int unsigned SLOT_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [SLOT_W-1:0]         slot_i,
  input  logic [DATA_W-1:0]         din,
  output logic [ARRAY_N*DATA_W-1:0] row_o,
  output logic                      full_o
);

  logic [ARRAY_N-1:0][DATA_W-1:0] slots_q, slots_d;
  logic [ARRAY_N-1:0][DATA_W-1:0] row_q, row_d;
  logic                           full_q, full_d;

  always_comb begin
    slots_d = slots_q;
    if (wr_en) slots_d[slot_i] = din;
    full_d = wr_en && (slot_i == SLOT_W'(ARRAY_N - 1));
    // Row is published from the post-write view so the last element lands in the same edge.
    row_d  = full_d ? slots_d : row_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slots_q <= '0;
      row_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      slots_q <= slots_d;
      row_q   <= row_d;
      full_q  <= full_d;
    end
  end

  assign row_o  = row_q;
  assign full_o = full_q;

endmodule

// File: rtl/conv_weight_loader.sv
// Weight-tile loader: fetches an ARRAY_N x ARRAY_N tile from SRAM and streams it
// row by row to the array. Define WLOAD_TRANSPOSE_EN for column-major fetch (W^T).
module conv_weight_loader
  import cnn_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ARRAY_N = ARRAY_N_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  conv_weight_loader_if.slave  wl
);

  localparam int unsigned TILE  = ARRAY_N * ARRAY_N;
  localparam int unsigned K_W   = idx_w(TILE);
  localparam int unsigned ROW_W = idx_w(ARRAY_N);

  wl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              rd_pend_q, rd_pend_d;
  logic [K_W-1:0]    rd_k_q, rd_k_d;
  logic [ROW_W-1:0]  w_row_q, w_row_d;

  logic              active;
  logic              capture_en;
  logic [ROW_W-1:0]  slot;
  logic              row_full;
  logic [ADDR_W-1:0] offset;

  always_comb begin
    active      = ((state_q == WL_FETCH) || (state_q == WL_DRAIN)) && wl.load_i;
    wl.mem_rd_en = (state_q == WL_FETCH) && wl.load_i;
`ifdef WLOAD_TRANSPOSE_EN
    offset = ADDR_W'((32'(k_q) % ARRAY_N) * ARRAY_N + 32'(k_q) / ARRAY_N);
`else
    offset = ADDR_W'(k_q);
`endif
    wl.mem_addr = wl.mem_rd_en ? (base_q + offset) : '0;

    // Returning read data is dropped once the request goes away.
    capture_en = rd_pend_q && active;
    slot       = ROW_W'(32'(rd_k_q) % ARRAY_N);
    wl.w_valid = row_full && active;
    wl.done    = (state_q == WL_DONE);

    rd_pend_d = wl.mem_rd_en;
    rd_k_d    = k_q;
    w_row_d   = (capture_en && (slot == ROW_W'(ARRAY_N - 1)))
                ? ROW_W'(32'(rd_k_q) / ARRAY_N) : w_row_q;

    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    unique case (state_q)
      WL_IDLE: begin
        if (wl.load_i) begin
          base_d  = wl.base_addr_i;
          k_d     = '0;
          state_d = WL_FETCH;
        end
      end
      WL_FETCH: begin
        if (!wl.load_i) begin
          state_d = WL_IDLE;
        end else begin
          k_d = k_q + 1'b1;
          if (k_q == K_W'(TILE - 1)) state_d = WL_DRAIN;
        end
      end
      WL_DRAIN: begin
        if (!wl.load_i) state_d = WL_IDLE;
        else if (wl.w_valid && (w_row_q == ROW_W'(ARRAY_N - 1))) state_d = WL_DONE;
      end
      WL_DONE:    state_d = WL_RELEASE;
      WL_RELEASE: if (!wl.load_i) state_d = WL_IDLE;
      default:    state_d = WL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WL_IDLE;
      base_q    <= '0;
      k_q       <= '0;
      rd_pend_q <= 1'b0;
      rd_k_q    <= '0;
      w_row_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      k_q       <= k_d;
      rd_pend_q <= rd_pend_d;
      rd_k_q    <= rd_k_d;
      w_row_q   <= w_row_d;
    end
  end

  wload_row_buf #(
    .DATA_W  (DATA_W),
    .ARRAY_N (ARRAY_N),
    .SLOT_W  (ROW_W)
  ) u_row_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (capture_en),
    .slot_i  (slot),
    .din     (wl.mem_rdata),
    .row_o   (wl.w_data),
    .full_o  (row_full)
  );

  assign wl.w_row = w_row_q;

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: behavioural SRAM plus a tile-level reference
// model of addresses, delivered rows and timing.
module tb_conv_weight_loader;
  import cnn_ctrl_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  logic [DW-1:0] mem [1024];

  always #5 clk = ~clk;

  conv_weight_loader_if #(.DATA_W(DW), .ARRAY_N(N), .ADDR_W(AW)) wl ();

  conv_weight_loader #(.DATA_W(DW), .ARRAY_N(N), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wl      (wl.slave)
  );

  // SRAM: data valid exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (wl.mem_rd_en) wl.mem_rdata <= mem[wl.mem_addr];
    else              wl.mem_rdata <= DW'($urandom);
  end

  function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] b, input int k);
`ifdef WLOAD_TRANSPOSE_EN
    return b + AW'((k % N) * N + k / N);
`else
    return b + AW'(k);
`endif
  endfunction

  // Drives one full request from its rising edge (cycle 0) for 'hold' cycles, then drops it.
  task automatic do_tile(input logic [AW-1:0] b, input int hold, input string name);
    logic [AW-1:0]     exp_addr[$];
    logic [N*DW-1:0]   exp_row[$];
    logic [N*DW-1:0]   r;
    int nrd = 0, nv = 0, ndone = 0, done_cyc = -1;
    for (int k = 0; k < N * N; k++) exp_addr.push_back(ref_addr(b, k));
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) r[j*DW +: DW] = mem[exp_addr[i*N + j]];
      exp_row.push_back(r);
    end
    wl.base_addr_i = b;
    wl.load_i      = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (wl.mem_rd_en) begin
        checks++;
        if (nrd >= N * N || c != nrd + 1 || wl.mem_addr !== exp_addr[nrd]) begin
          errors++;
          $display("FAIL %s read: cycle %0d addr %h, required read #%0d at cycle %0d addr %h",
                   name, c, wl.mem_addr, nrd, nrd + 1, (nrd < N * N) ? exp_addr[nrd] : 'x);
        end
        nrd++;
      end
      if (wl.w_valid) begin
        checks++;
        if (nv >= N || c != 4 * nv + 6 || wl.w_row !== 2'(nv) || wl.w_data !== exp_row[nv]) begin
          errors++;
          $display("FAIL %s row: cycle %0d row %0d data %h, required row %0d at cycle %0d data %h",
                   name, c, wl.w_row, wl.w_data, nv, 4 * nv + 6, (nv < N) ? exp_row[nv] : 'x);
        end
        nv++;
      end
      if (wl.done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nrd != N * N || nv != N || ndone != 1 || done_cyc != N * N + 3) begin
      errors++;
      $display("FAIL %s totals: reads %0d rows %0d done %0d at cycle %0d, required 16 4 1 at 19",
               name, nrd, nv, ndone, done_cyc);
    end
    wl.load_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({wl.mem_rd_en, wl.mem_addr, wl.w_valid, wl.w_row, wl.w_data, wl.done} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got rd %b addr %h v %b row %0d data %h done %b, required all 0",
               wl.mem_rd_en, wl.mem_addr, wl.w_valid, wl.w_row, wl.w_data, wl.done);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_row_major();
    for (int i = 0; i < N * N; i++) mem[10'h040 + i] = DW'(i);
    do_tile(10'h040, 25, "row_major");
  endtask

  task automatic test_held_request();
    do_tile(10'h155, 40, "held");
    do_tile(10'h2A0, 25, "after_held");
  endtask

  task automatic test_abort();
    int bad = 0;
    wl.base_addr_i = 10'h080;
    wl.load_i      = 1'b1;
    repeat (7) @(posedge clk);
    #1 wl.load_i = 1'b0;
    #1;
    checks++;
    if (wl.mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL abort rd_en: got %b, required 0", wl.mem_rd_en);
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (wl.w_valid || wl.done || wl.mem_rd_en) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort quiet: got %0d active cycles, required 0", bad);
    end
    @(posedge clk); #1;
    do_tile(10'h100, 25, "after_abort");
  endtask

  task automatic test_async_reset();
    wl.base_addr_i = 10'h200;
    wl.load_i      = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    checks++;
    if (wl.mem_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset rd_en: got %b, required 1", wl.mem_rd_en);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wl.mem_rd_en, wl.mem_addr, wl.w_valid, wl.w_row, wl.w_data, wl.done} !== '0) begin
      errors++;
      $display("FAIL async_reset outputs: got rd %b addr %h v %b row %0d data %h done %b, required all 0",
               wl.mem_rd_en, wl.mem_addr, wl.w_valid, wl.w_row, wl.w_data, wl.done);
    end
    wl.load_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    do_tile(10'h200, 25, "after_reset");
  endtask

  task automatic test_wrap();
    do_tile(10'h3FC, 25, "wrap");
  endtask

  task automatic test_ident_base0();
    for (int i = 0; i < N * N; i++) mem[i] = DW'(i);
    do_tile(10'h000, 25, "ident_base0");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
      do_tile(AW'($urandom), 20 + int'($urandom_range(0, 5)), "random_tile");
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    wl.load_i      = 1'b0;
    wl.base_addr_i = '0;
    wl.mem_rdata   = '0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    test_reset();
    test_row_major();
    test_held_request();
    test_abort();
    test_async_reset();
    test_wrap();
    test_ident_base0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
